// File: rtl/hex_display_bank.sv
// Multi-digit seven-segment driver: hex or BCD (shift-add-3) display with
// leading-zero blanking, overflow dashes and whole-display blink.
module hex_display_bank #(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  mode_dec,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned BIT_W = $clog2(W);
    localparam int unsigned CNT_W = $clog2(BLINK_DIV);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [63:0] max_dec(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC = max_dec(DIGITS);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_e;

    // One double-dabble step: correct every BCD digit, then shift in the next bit.
    function automatic logic [W-1:0] dabble(input logic [W-1:0] bcd, input logic bit_in);
        logic [W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return {adj[W-2:0], bit_in};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [W-1:0]       shift_q, shift_d;
    logic [W-1:0]       bcd_q, bcd_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [W-1:0]       digits_q, digits_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               phase_on_q, phase_on_d;
    logic               post_rst_q, post_rst_d;
    logic [DIGITS-1:0]  upper_zero;

    // Request capture and bit-serial conversion
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        post_rst_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mode_dec) begin
                        state_d    = S_CONV;
                        busy_d     = 1'b1;
                        bit_cnt_d  = '0;
                        shift_d    = value;
                        bcd_d      = '0;
                        ovf_pend_d = (64'(value) > MAX_DEC);
                    end else begin
                        digits_d   = value;
                        overflow_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            S_CONV: begin
                bcd_d     = dabble(bcd_q, shift_q[W-1]);
                shift_d   = {shift_q[W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_W'(W - 1)) begin
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                    digits_d   = bcd_d;
                    overflow_d = ovf_pend_q;
                    done_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Blink phase: free-running while enabled, parked at "on" otherwise
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_on_d  = phase_on_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_on_d  = 1'b1;
        end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_on_d  = ~phase_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            bcd_q       <= '0;
            ovf_pend_q  <= 1'b0;
            digits_q    <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
            post_rst_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            ovf_pend_q  <= ovf_pend_d;
            digits_q    <= digits_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
            post_rst_q  <= post_rst_d;
        end
    end

    // upper_zero[i]: digit i and every digit above it are zero
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            run           = run & (digits_q[4*i +: 4] == 4'd0);
            upper_zero[i] = run;
        end
    end

    // Segment mapping; blanking priority: reset/blink > overflow dash > leading zero
    always_comb begin
        logic [6:0] seg;
        seg = SEG_BLANK;
        hex = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            seg = seg7(digits_q[4*i +: 4]);
            if (blank_lz && (i != 0) && upper_zero[i]) begin
                seg = SEG_BLANK;
            end
            if (overflow_q) begin
                seg = SEG_DASH;
            end
            if (reset || post_rst_q || (blink_en && !phase_on_q)) begin
                seg = SEG_BLANK;
            end
            hex[7*i +: 7] = seg;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Randomized scoreboard bench for hex_display_bank (DIGITS=4, BLINK_DIV=4).
module tb_hex_display_bank;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned BLINK_DIV = 4;
    localparam int          W         = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] value;
    logic        mode_dec;
    logic        blank_lz;
    logic        blink_en;
    logic [27:0] hex;
    logic        busy;
    logic        done;
    logic        overflow;

    hex_display_bank #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .mode_dec (mode_dec),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .hex      (hex),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          exp_cycle;
        bit          dec;
        bit          ovf;
        logic [15:0] digs;
    } txn_t;

    txn_t        sb[$];
    int          cyc        = 0;
    logic        post_rst   = 1'b0;
    int          blink_base = 0;
    logic [15:0] disp_digs  = 16'h0;
    logic        disp_ovf   = 1'b0;
    int          total      = 0;
    int          bad        = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] model_digits(input int v, input bit dec);
        logic [15:0] r;
        int p;
        r = 16'h0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (dec) r[4*i +: 4] = 4'((v / p) % 10);
            else     r[4*i +: 4] = 4'((v >> (4 * i)) & 15);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic bit busy_at(input int c);
        bit b;
        b = 1'b0;
        foreach (sb[j]) begin
            if (sb[j].dec && (c >= sb[j].exp_cycle - W) && (c < sb[j].exp_cycle)) b = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [27:0] exp_hex();
        logic [27:0] h;
        logic [6:0]  code;
        int          msd;
        bit          blink_on;
        msd = 0;
        for (int i = 0; i < 4; i++) if (disp_digs[4*i +: 4] != 4'd0) msd = i;
        blink_on = (((cyc - blink_base) / int'(BLINK_DIV)) % 2) == 0;
        h = '1;
        for (int i = 0; i < 4; i++) begin
            code = seg_tab[int'(disp_digs[4*i +: 4])];
            if (blank_lz && i > msd) code = 7'h7F;
            if (disp_ovf) code = 7'h3F;
            if (reset || post_rst || (blink_en && !blink_on)) code = 7'h7F;
            h[7*i +: 7] = code;
        end
        return h;
    endfunction

    // Reference-model bookkeeping at the active edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        post_rst = reset;
        if (reset) begin
            sb.delete();
            disp_digs = 16'h0;
            disp_ovf  = 1'b0;
        end
        if (reset || !blink_en) blink_base = cyc;
    end

    // Monitor: retire expected results and compare outputs away from the edge
    always @(negedge clk) begin
        if (cyc >= 1) begin
            txn_t t;
            bit   ed;
            ed = (sb.size() > 0) && (sb[0].exp_cycle == cyc);
            check("done", 32'(done), 32'(ed));
            if (ed) begin
                t = sb.pop_front();
                disp_digs = t.digs;
                disp_ovf  = t.ovf;
            end
            check("busy", 32'(busy), 32'(busy_at(cyc)));
            check("overflow", 32'(overflow), 32'(disp_ovf));
            check("hex", 32'(hex), 32'(exp_hex()));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] v, input bit dec);
        txn_t t;
        start    = 1'b1;
        value    = v;
        mode_dec = dec;
        if (!busy_at(cyc)) begin
            t.exp_cycle = dec ? cyc + W + 1 : cyc + 1;
            t.dec       = dec;
            t.ovf       = dec && (int'(v) > 9999);
            t.digs      = model_digits(int'(v), dec);
            sb.push_back(t);
        end
        tick(1);
        start    = 1'b0;
        value    = 16'($urandom);
        mode_dec = 1'($urandom);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        value    = 16'h0;
        mode_dec = 1'b0;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(3);
        blank_lz = 1'b1;
        tick(2);

        issue(16'h00A3, 1'b0);
        tick(3);
        issue(16'd1234, 1'b1);
        tick(20);
        issue(16'd12345, 1'b1);
        tick(18);
        issue(16'h0005, 1'b0);
        tick(3);

        // second start mid-conversion must be ignored
        issue(16'd4321, 1'b1);
        tick(4);
        issue(16'd777, 1'b1);
        tick(15);

        blank_lz = 1'b0;
        issue(16'h0042, 1'b0);
        tick(2);
        blink_en = 1'b1;
        tick(20);
        blink_en = 1'b0;
        tick(3);

        // reset in the middle of a decimal conversion
        blank_lz = 1'b1;
        issue(16'd9876, 1'b1);
        tick(6);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(4);

        for (int n = 0; n < 60; n++) begin
            logic [15:0] v;
            blank_lz = 1'($urandom);
            if ($urandom_range(0, 3) == 0) blink_en = ~blink_en;
            v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            issue(v, 1'($urandom));
            tick($urandom_range(0, 20));
        end

        blink_en = 1'b0;
        tick(W + 4);
        check("drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_bank.md
HEX_DISPLAY_BANK -- requirements
Module: hex_display_bank

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; reset is sampled on the rising edge of clk.
REQ-002 Parameter DIGITS SHALL default to 6 and set the number of seven-segment digits (range 1..8); W = 4*DIGITS.
REQ-003 Parameter BLINK_DIV SHALL default to 25000000 and set the blink half-period in clk cycles (minimum 2).
REQ-004 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle request to capture value and mode
- value  in  W  unsigned binary value to display
- mode_dec  in  1  0 = hex display, 1 = decimal (BCD) display
- blank_lz  in  1  1 = blank leading zero digits
- blink_en  in  1  1 = blink the whole display
- hex  out  7*DIGITS  active-low segments; digit i at [7i+6:7i], bit 0 = segment a ... bit 6 = segment g; digit 0 is least significant
- busy  out  1  decimal conversion in progress
- done  out  1  one-cycle pulse when a new display value takes effect
- overflow  out  1  latched; the last decimal request exceeded 10^DIGITS-1

Function
REQ-005 Segment codes (active-low) SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex); blank = 7F; dash = 3F.
REQ-006 start SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-007 On acceptance, value, mode_dec, and the overflow compare SHALL be captured on that edge (edge k); later input changes SHALL NOT affect this request.
REQ-008 Hex mode: the digit register SHALL load value nibbles directly on edge k+1; done=1 SHALL be visible during cycle k+1; overflow SHALL clear; busy SHALL stay 0.
REQ-009 Decimal mode: busy=1 SHALL be visible for exactly W cycles, k+1..k+W; an iterative shift-add-3 conversion SHALL process one input bit per cycle, MSB first.
REQ-010 Decimal mode: the digit register, overflow, and done=1 SHALL update together on the edge at which busy falls, so they are visible in cycle k+W+1.
REQ-011 Decimal overflow (value > 10^DIGITS-1) SHALL set overflow=1, and every digit SHALL show dash; the conversion still runs its full W cycles.
REQ-012 The digit register and outputs SHALL hold the previous display throughout a conversion.
REQ-013 done SHALL be high for exactly one cycle per accepted request and SHALL otherwise be 0.
REQ-014 Leading-zero blanking (blank_lz=1, not overflow): every digit above the most significant nonzero digit SHALL show blank; digit 0 SHALL always be shown, so value 0 displays "0".
REQ-015 blank_lz and blink_en SHALL act combinationally on the registered digits; they SHALL NOT require a new start.
REQ-016 Blink: with blink_en=1, a phase counter SHALL toggle the display between normal (phase on) and all-7F (phase off) every BLINK_DIV cycles, starting with phase on.
REQ-017 When blink_en=0, the blink counter SHALL reset to 0 and the phase SHALL reset to on.
REQ-018 The blink counter SHALL wrap without skipping or duplicating cycles; it SHALL keep running through conversions.

Reset
REQ-019 Reset SHALL force busy=0, done=0, overflow=0, the digit register to all zero, the blink counter to 0 and phase on, and the conversion state to idle.
REQ-020 While reset is asserted and on the first cycle after reset, hex SHALL be all 7F.
REQ-021 After reset, hex SHALL show the zero digit register per REQ-014 and REQ-016 until the first done.
REQ-022 Reset asserted mid-conversion SHALL abort the conversion, with no done pulse and the display cleared per REQ-019.

Verification (DIGITS=4, BLINK_DIV=4)
REQ-023 Hex mode: start, value=16'h00A3, blank_lz=1 -> cycle k+1: done=1; digit0=30, digit1=08, digit2=7F, digit3=7F.
REQ-024 Decimal mode: start, value=16'd1234 -> busy cycles k+1..k+16; cycle k+17: done=1; digits0..3 = 19, 30, 24, 79; overflow=0.
REQ-025 Decimal overflow: start, value=16'd12345 -> cycle k+17: overflow=1; all digits 3F. A following hex start clears overflow.
REQ-026 start pulsed again at k+5 during a decimal conversion -> ignored; exactly one done pulse, at k+17.
REQ-027 Blink: blink_en=1 with display "0042" and blank_lz=0 -> 4 cycles normal, 4 cycles all 7F, repeating; blink_en=0 -> normal display the next cycle.
REQ-028 Reset at k+8 of a decimal conversion -> busy=0 the next cycle, no done, hex all 7F, then "0" shown with blank_lz=1.
